c17_bist: RTL and testbench

- Built-in self-test wrapper stage for the c17 combinational core.
- Upstream half: a 5-bit maximal-length LFSR drives the core inputs N1, N2, N3, N6, N7.
- Downstream half: a 16-bit MISR compacts the core outputs N22, N23 into a signature.
- A start/busy/done FSM sequences one test run, compares the final signature against a golden value and reports pass/fail.

---
 rtl/c17_bist_pkg.sv | 35 +++
 rtl/c17_bist_misr.sv | 34 +++
 rtl/c17_bist.sv | 127 ++++++++++++
 tb/tb_c17_bist.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg: shared types and constants for the c17 BIST wrapper.
// State encoding, LFSR/MISR polynomials, widths and step helpers.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam int PAT_W  = 5;
  localparam int RESP_W = 2;
  localparam int SIG_W  = 16;

  // x^5+x^3+1 in Fibonacci form: feedback = lfsr[4] ^ lfsr[2]
  localparam logic [PAT_W-1:0] LFSR_POLY_TAPS = 5'b10100;
  localparam logic [SIG_W-1:0] MISR_POLY      = 16'h1021;

  function automatic logic [PAT_W-1:0] lfsr_next(
    input logic [PAT_W-1:0] s
  );
    return {s[PAT_W-2:0], ^(s & LFSR_POLY_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0]  m,
    input logic [RESP_W-1:0] r
  );
    logic [SIG_W-1:0] fb;
    fb = m[SIG_W-1] ? MISR_POLY : '0;
    return {m[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// c17_bist_misr: 16-bit MISR compacting the c17 responses.
// Ports: clk, rst (async high), clr (sync), en, resp -> sig, sig_nxt.
module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_nxt
);

  // sig_nxt is exposed so the owner can judge the signature
  // on the same edge that absorbs the final response.
  always_comb begin
    sig_nxt = sig;
    if (clr) begin
      sig_nxt = '0;
    end else if (en) begin
      sig_nxt = misr_step(sig, resp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/c17_bist.sv
// c17_bist: LFSR stimulus, MISR compaction and run FSM for c17.
// Ports: blif_clk_net, blif_reset_net, start, resp -> pat, busy, done, pass, signature.
module c17_bist
  import c17_bist_pkg::*;
#(
  parameter int               NUM_PATTERNS = 31,
  parameter logic [PAT_W-1:0] LFSR_SEED    = 5'b00001,
  parameter int               RESP_DELAY   = 0,
  parameter logic [SIG_W-1:0] GOLDEN       = 16'h0000
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [RESP_W-1:0] resp,
  output logic [PAT_W-1:0]  pat,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [4:0] RUN_LAST =
    5'(NUM_PATTERNS - 1);
  localparam logic [4:0] FL_LAST =
    (RESP_DELAY > 0) ? 5'(RESP_DELAY - 1) : 5'd0;

  state_t           state;
  logic [PAT_W-1:0] lfsr;
  logic [4:0]       cnt;
  logic             armed;
  logic             launch;
  logic             cap_valid;
  logic             start_go;
  logic [SIG_W-1:0] sig_nxt;

  // armed stays low for the first edge after reset release so a
  // start coinciding with release is dropped.
  assign start_go = (state == IDLE) && start && armed;
  assign launch   = (state == RUN);
  assign pat      = lfsr;

  generate
    if (RESP_DELAY == 0) begin : g_nopipe
      assign cap_valid = launch;
    end else begin : g_pipe
      logic [RESP_DELAY-1:0] pipe;
      always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
          pipe <= '0;
        end else begin
          pipe <= (pipe << 1) | RESP_DELAY'(launch);
        end
      end
      assign cap_valid = pipe[RESP_DELAY-1];
    end
  endgenerate

  c17_bist_misr u_misr (
    .clk     (blif_clk_net),
    .rst     (blif_reset_net),
    .clr     (start_go),
    .en      (cap_valid),
    .resp    (resp),
    .sig     (signature),
    .sig_nxt (sig_nxt)
  );

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state <= IDLE;
      lfsr  <= '0;
      cnt   <= '0;
      armed <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_go) begin
            state <= RUN;
            lfsr  <= LFSR_SEED;
            cnt   <= '0;
            pass  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          lfsr <= lfsr_next(lfsr);
          if (cnt == RUN_LAST) begin
            cnt <= '0;
            if (RESP_DELAY > 0) begin
              state <= FLUSH;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_nxt == GOLDEN);
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FLUSH: begin
          if (cnt == FL_LAST) begin
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_nxt == GOLDEN);
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist.sv
// tb_c17_bist: directed checks of c17_bist against a bench model.
// Three DUT copies: defaults, GOLDEN from model, and RESP_DELAY=2.
module tb_c17_bist;

  function automatic logic [1:0] c17f(
    input logic [4:0] p,
    input bit         f
  );
    logic n1, n2, n3, n6, n7;
    logic n10, n11, n16, n19, n22, n23;
    {n1, n2, n3, n6, n7} = p;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    n22 = f ? 1'b0 : ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {n22, n23};
  endfunction

  function automatic logic [15:0] ref_sig(input bit f);
    logic [4:0]  l;
    logic [15:0] m;
    l = 5'b00001;
    m = 16'h0000;
    for (int i = 0; i < 31; i++) begin
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)
          ^ {14'b0, c17f(l, f)};
      l = {l[3:0], l[4] ^ l[2]};
    end
    return m;
  endfunction

  localparam logic [15:0] REF = ref_sig(1'b0);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st  = 3'b000;
  logic [2:0]  bz, dn, ps;
  logic [4:0]  pt [3];
  logic [15:0] sg [3];
  logic [1:0]  r0, r1, r2, d1;
  bit          fault = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] pq[$];

  always #5 clk = ~clk;

  assign r0 = 2'b00;
  assign r1 = c17f(pt[1], fault);

  always @(posedge clk) begin
    d1 <= c17f(pt[2], 1'b0);
    r2 <= d1;
  end

  c17_bist u0 (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .start(st[0]), .resp(r0), .pat(pt[0]),
    .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .signature(sg[0])
  );

  c17_bist #(.GOLDEN(REF)) u1 (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .start(st[1]), .resp(r1), .pat(pt[1]),
    .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .signature(sg[1])
  );

  c17_bist #(.RESP_DELAY(2), .GOLDEN(REF)) u2 (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .start(st[2]), .resp(r2), .pat(pt[2]),
    .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .signature(sg[2])
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // len counts clock edges from the start edge (inclusive) to the
  // edge that raises done; 0 means no done within the budget.
  task automatic run(
    input  int u,
    input  bit glitch,
    input  int abort_at,
    output int len,
    output int bcnt
  );
    len  = 0;
    bcnt = 0;
    pq.delete();
    @(negedge clk);
    st[u] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) st[u] = 1'b0;
      if (glitch && k == 6) st[u] = 1'b1;
      if (glitch && k == 7) st[u] = 1'b0;
      if (bz[u]) begin
        bcnt++;
        pq.push_back(pt[u]);
      end
      if (k == abort_at || dn[u]) begin
        len = k;
        break;
      end
    end
    if (glitch && len != 0) begin
      st[u] = 1'b1;
      @(negedge clk);
      st[u] = 1'b0;
    end
  endtask

  task automatic quiet(
    input  int u,
    input  int n,
    output int c
  );
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dn[u]) c++;
    end
  endtask

  typedef struct {
    int          idx;
    logic [4:0]  pat;
  } pat_vec_t;

  typedef struct {
    int          u;
    bit          f;
    int          len;
    int          busy;
    logic [15:0] sig;
    bit          sig_ne;
    bit          pass;
  } run_vec_t;

  initial begin
    pat_vec_t pv[5];
    run_vec_t rv[4];
    int len, bc, c;
    bit seen[32];
    int distinct;

    pv[0] = '{0, 5'b00001};
    pv[1] = '{1, 5'b00010};
    pv[2] = '{2, 5'b00100};
    pv[3] = '{3, 5'b01001};
    pv[4] = '{4, 5'b10010};

    rv[0] = '{0, 1'b0, 32, 31, 16'h0000, 1'b0, 1'b1};
    rv[1] = '{1, 1'b0, 32, 31, REF,      1'b0, 1'b1};
    rv[2] = '{2, 1'b0, 34, 33, REF,      1'b0, 1'b1};
    rv[3] = '{1, 1'b1, 32, 31, REF,      1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_pat",  32'(pt[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_pass", 32'(ps[0]), 0);
    chk("rst_sig",  32'(sg[0]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      fault = rv[r].f;
      run(rv[r].u, 1'b0, 0, len, bc);
      chk($sformatf("run%0d_len", r),  32'(len), 32'(rv[r].len));
      chk($sformatf("run%0d_busy", r), 32'(bc),  32'(rv[r].busy));
      chk($sformatf("run%0d_pass", r),
          32'(ps[rv[r].u]), 32'(rv[r].pass));
      if (rv[r].sig_ne)
        chk($sformatf("run%0d_sig_differs", r),
            32'(sg[rv[r].u] != rv[r].sig), 1);
      else
        chk($sformatf("run%0d_sig", r),
            32'(sg[rv[r].u]), 32'(rv[r].sig));
      if (r == 0) begin
        for (int i = 0; i < 5; i++)
          chk($sformatf("seed_pat%0d", pv[i].idx),
              32'((pq.size() > pv[i].idx) ? pq[pv[i].idx] : 5'b0),
              32'(pv[i].pat));
      end
      if (r == 1) begin
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (pq[i]) seen[pq[i]] = 1'b1;
        distinct = 0;
        for (int i = 1; i < 32; i++) if (seen[i]) distinct++;
        chk("cover_distinct", 32'(distinct), 31);
        chk("cover_nozero", 32'(seen[0]), 0);
      end
      fault = 1'b0;
      repeat (3) @(negedge clk);
    end

    run(1, 1'b1, 0, len, bc);
    chk("proto_len",  32'(len), 32);
    chk("proto_pass", 32'(ps[1]), 1);
    quiet(1, 40, c);
    chk("proto_no_extra_done", 32'(c), 0);
    chk("proto_idle", 32'(bz[1]), 0);

    run(1, 1'b0, 0, len, bc);
    chk("b2b_first_len", 32'(len), 32);
    run(1, 1'b0, 0, len, bc);
    chk("b2b_second_len", 32'(len), 32);
    chk("b2b_second_sig", 32'(sg[1]), 32'(REF));

    run(1, 1'b0, 11, len, bc);
    chk("abort_reached", 32'(len), 11);
    rst = 1'b1;
    #1;
    chk("abort_pat",  32'(pt[1]), 0);
    chk("abort_busy", 32'(bz[1]), 0);
    chk("abort_done", 32'(dn[1]), 0);
    chk("abort_sig",  32'(sg[1]), 0);
    @(negedge clk);
    rst   = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("start_at_release_busy", 32'(bz[0]), 0);
    quiet(1, 40, c);
    chk("abort_no_done", 32'(c), 0);
    chk("release_start_idle", 32'(bz[0]), 0);

    run(1, 1'b0, 0, len, bc);
    chk("after_abort_len",  32'(len), 32);
    chk("after_abort_sig",  32'(sg[1]), 32'(REF));
    chk("after_abort_pass", 32'(ps[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
